// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the pipelined MIPS execute stage:
//   - R-type funct codes used by the ALU decoder
//   - aluop encodings issued by the main decoder
//   - execute-stage FSM state enum
//   - control portion of the EX/MEM entry (datapath fields are XLEN-sized and
//     live as separate registers in exe_stage_pipe)
// -----------------------------------------------------------------------------
package exe_pkg;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    MUL_DONE
  } ex_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] wb_ctl;    // {RegWrite, MemToReg}
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       ovf;
  } exmem_ctl_t;

endpackage

// File: rtl/exe_stage_pipe_seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
// Iterative signed multiplier: one shift-add step per clock on the operand
// magnitudes, sign applied to the final 2*XLEN product. XLEN steps total.
//   clk, rst_n   clock / async active-low reset
//   start_i      latch a_i/b_i and begin (ignored while abort_i)
//   abort_i      cancel any operation in flight, count back to 0
//   a_i, b_i     signed operands
//   done_o       high during the final step; product_o valid that cycle
//   product_o    signed 2*XLEN product
// -----------------------------------------------------------------------------
module seq_mult #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic                done_o,
  output logic [2*XLEN-1:0]   product_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic                active_q, active_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   step;
  logic [XLEN-1:0]     abs_a, abs_b;

  // The final step's result is exposed combinationally so the caller can
  // commit HI/LO on the same edge the last step would have been registered.
  always_comb begin
    sum       = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({(XLEN+1){prod_q[0]}} & {1'b0, mcand_q});
    step      = {sum, prod_q[XLEN-1:1]};
    done_o    = active_q && (count_q == LAST);
    product_o = neg_q ? -step : step;
    abs_a     = a_i[XLEN-1] ? -a_i : a_i;
    abs_b     = b_i[XLEN-1] ? -b_i : b_i;
  end

  always_comb begin
    active_d = active_q;
    neg_d    = neg_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    if (abort_i) begin
      active_d = 1'b0;
      count_d  = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      count_d  = '0;
      neg_d    = a_i[XLEN-1] ^ b_i[XLEN-1];
      mcand_d  = abs_a;
      prod_d   = {{XLEN{1'b0}}, abs_b};
    end else if (active_q) begin
      prod_d = step;
      if (count_q == LAST) begin
        active_d = 1'b0;
        count_d  = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
    end else begin
      active_q <= active_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// -----------------------------------------------------------------------------
// exe_stage_pipe
// Registered MIPS execute stage: ALU, branch-target adder, destination mux,
// owned EX/MEM register, valid/ready handshake, stall/flush, and an iterative
// signed MULT writing HI/LO (in_ready low for XLEN cycles after accept).
//
// Ports:
//   in_valid/in_ready      ID/EX handshake (transfer = in_valid & in_ready)
//   flush                  synchronous kill of EX/MEM and any in-flight MULT
//   out_stall              MEM cannot accept; EX/MEM holds
//   wb_ctl, m_ctl, regdst, alusrc, aluop, funct   decoded control
//   npc, rdata1, rdata2, s_extend, rt_addr, rd_addr  datapath inputs
//   exmem_*                registered EX/MEM entry
//   ex_ovf                 signed-overflow flag of the current entry
//
// Build option: define EXE_OVF_TRAP_EN to flag signed overflow on add/sub
// (funct 100000/100010) and suppress the write-back; otherwise ex_ovf is 0.
// -----------------------------------------------------------------------------
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_stall,
  input  logic [1:0]       wb_ctl,
  input  logic [2:0]       m_ctl,
  input  logic             regdst,
  input  logic             alusrc,
  input  logic [1:0]       aluop,
  input  logic [XLEN-1:0]  npc,
  input  logic [XLEN-1:0]  rdata1,
  input  logic [XLEN-1:0]  rdata2,
  input  logic [XLEN-1:0]  s_extend,
  input  logic [RA_W-1:0]  rt_addr,
  input  logic [RA_W-1:0]  rd_addr,
  input  logic [5:0]       funct,
  output logic             exmem_valid,
  output logic [1:0]       exmem_wb_ctl,
  output logic             exmem_branch,
  output logic             exmem_memread,
  output logic             exmem_memwrite,
  output logic [XLEN-1:0]  exmem_btarget,
  output logic             exmem_zero,
  output logic [XLEN-1:0]  exmem_alu_result,
  output logic [XLEN-1:0]  exmem_rdata2,
  output logic [RA_W-1:0]  exmem_dst,
  output logic             ex_ovf
);

  ex_state_e         state_q, state_d;
  logic [XLEN-1:0]   hi_q, lo_q;

  exmem_ctl_t        ctl_q, ctl_d;
  logic [XLEN-1:0]   alu_q, alu_d, bt_q, bt_d, rd2_q, rd2_d;
  logic              zero_q, zero_d;
  logic [RA_W-1:0]   dst_q, dst_d;

  logic [XLEN-1:0]   opb, sum, diff, alu_res, btarget, mult_lo;
  logic              is_mult, trap;
  logic              accept, mul_start, mul_done, hilo_we;
  logic              ld_normal, ld_mult, ld_bubble;
  logic [2*XLEN-1:0] mul_product;

  seq_mult #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .abort_i   (flush),
    .a_i       (rdata1),
    .b_i       (opb),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // ---------------- datapath ----------------
  always_comb begin
    opb     = alusrc ? s_extend : rdata2;
    sum     = rdata1 + opb;
    diff    = rdata1 - opb;
    btarget = npc + {s_extend[XLEN-3:0], 2'b00};
    is_mult = (aluop_e'(aluop) == ALUOP_FUNCT) && (funct == F_MULT);
    alu_res = sum;
    unique case (aluop_e'(aluop))
      ALUOP_SUB:   alu_res = diff;
      ALUOP_FUNCT: begin
        unique case (funct)
          F_ADD, F_ADDU: alu_res = sum;
          F_SUB, F_SUBU: alu_res = diff;
          F_AND:         alu_res = rdata1 & opb;
          F_OR:          alu_res = rdata1 | opb;
          F_NOR:         alu_res = ~(rdata1 | opb);
          F_SLT:         alu_res = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(opb))};
          F_MFHI:        alu_res = hi_q;
          F_MFLO:        alu_res = lo_q;
          default:       alu_res = '0;
        endcase
      end
      default:     alu_res = sum;
    endcase
  end

`ifdef EXE_OVF_TRAP_EN
  logic ovf_add, ovf_sub;
  always_comb begin
    ovf_add = (rdata1[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1]  != rdata1[XLEN-1]);
    ovf_sub = (rdata1[XLEN-1] != opb[XLEN-1]) && (diff[XLEN-1] != rdata1[XLEN-1]);
    trap    = (aluop_e'(aluop) == ALUOP_FUNCT) &&
              (((funct == F_ADD) && ovf_add) || ((funct == F_SUB) && ovf_sub));
  end
`else
  assign trap = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (mul_start) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_d = out_stall ? MUL_DONE : IDLE;
      MUL_DONE: if (!out_stall) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // ---------------- FSM: outputs / load selects ----------------
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE) && !out_stall;
    accept    = in_valid && in_ready && !flush;
    mul_start = accept && is_mult;
    hilo_we   = (state_q == MUL_BUSY) && mul_done && !flush;
    ld_mult   = !flush && !out_stall &&
                (((state_q == MUL_BUSY) && mul_done) || (state_q == MUL_DONE));
    ld_normal = accept && !is_mult;
    // idle cycle or MULT accept: push a bubble downstream
    ld_bubble = !flush && (state_q == IDLE) && !out_stall && !ld_normal;
    // on the completing edge LO is not yet registered, take it from the product
    mult_lo   = (state_q == MUL_BUSY) ? mul_product[XLEN-1:0] : lo_q;
  end

  // ---------------- EX/MEM next entry ----------------
  always_comb begin
    ctl_d  = ctl_q;
    alu_d  = alu_q;
    zero_d = zero_q;
    bt_d   = bt_q;
    rd2_d  = rd2_q;
    dst_d  = dst_q;
    if (flush) begin
      ctl_d = '0;
    end else if (ld_normal) begin
      ctl_d.valid    = 1'b1;
      ctl_d.wb_ctl   = trap ? 2'b00 : wb_ctl;
      ctl_d.branch   = m_ctl[2];
      ctl_d.memread  = m_ctl[1];
      ctl_d.memwrite = m_ctl[0];
      ctl_d.ovf      = trap;
      alu_d          = alu_res;
      zero_d         = (alu_res == '0);
      bt_d           = btarget;
      rd2_d          = rdata2;
      dst_d          = regdst ? rd_addr : rt_addr;
    end else if (ld_mult) begin
      ctl_d       = '0;
      ctl_d.valid = 1'b1;
      alu_d       = mult_lo;
      zero_d      = (mult_lo == '0);
      bt_d        = '0;
      rd2_d       = '0;
      dst_d       = '0;
    end else if (ld_bubble) begin
      ctl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
      bt_q   <= '0;
      rd2_q  <= '0;
      dst_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      ctl_q  <= ctl_d;
      alu_q  <= alu_d;
      zero_q <= zero_d;
      bt_q   <= bt_d;
      rd2_q  <= rd2_d;
      dst_q  <= dst_d;
      if (hilo_we) begin
        hi_q <= mul_product[2*XLEN-1:XLEN];
        lo_q <= mul_product[XLEN-1:0];
      end
    end
  end

  assign exmem_valid      = ctl_q.valid;
  assign exmem_wb_ctl     = ctl_q.wb_ctl;
  assign exmem_branch     = ctl_q.branch;
  assign exmem_memread    = ctl_q.memread;
  assign exmem_memwrite   = ctl_q.memwrite;
  assign ex_ovf           = ctl_q.ovf;
  assign exmem_btarget    = bt_q;
  assign exmem_zero       = zero_q;
  assign exmem_alu_result = alu_q;
  assign exmem_rdata2     = rd2_q;
  assign exmem_dst        = dst_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_pipe
// Directed bench for exe_stage_pipe. A cycle-level behavioural model tracks
// the expected EX/MEM entry, HI/LO and the MULT latency as a countdown; a
// compare process checks the DUT against it every cycle, and the directed
// sequence pins the model with hand-computed literal values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exe_stage_pipe;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, flush = 1'b0, out_stall = 1'b0;
  logic            in_ready;
  logic [1:0]      wb_ctl = '0, aluop = '0;
  logic [2:0]      m_ctl = '0;
  logic            regdst = 1'b0, alusrc = 1'b0;
  logic [31:0]     npc = '0, rdata1 = '0, rdata2 = '0, s_extend = '0;
  logic [4:0]      rt_addr = '0, rd_addr = '0;
  logic [5:0]      funct = '0;
  logic            exmem_valid, exmem_branch, exmem_memread, exmem_memwrite, exmem_zero, ex_ovf;
  logic [1:0]      exmem_wb_ctl;
  logic [31:0]     exmem_btarget, exmem_alu_result, exmem_rdata2;
  logic [4:0]      exmem_dst;

  always #5 clk = ~clk;

  exe_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_stall(out_stall), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
    .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npc(npc),
    .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .funct(funct),
    .exmem_valid(exmem_valid), .exmem_wb_ctl(exmem_wb_ctl),
    .exmem_branch(exmem_branch), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .exmem_btarget(exmem_btarget),
    .exmem_zero(exmem_zero), .exmem_alu_result(exmem_alu_result),
    .exmem_rdata2(exmem_rdata2), .exmem_dst(exmem_dst), .ex_ovf(ex_ovf)
  );

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;
`ifdef EXE_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 0, m_br = 0, m_mr = 0, m_mw = 0, m_ovf = 0, m_zero = 0;
  logic [1:0]  m_wb = 0;
  logic [31:0] m_alu = 0, m_bt = 0, m_rd2 = 0, m_hi = 0, m_lo = 0;
  logic [4:0]  m_dst = 0;
  logic [63:0] m_prod = 0;
  bit          m_full = 0, m_mulent = 0, m_wait = 0;
  int          m_left = 0;

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h27:        return ~(a | b);
      6'h2a:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h10:        return m_hi;
      6'h12:        return m_lo;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic bit ref_ovf(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (!TRAP || op != 2'b10) return 1'b0;
    if (f == 6'h20)      s = longint'($signed(a)) + longint'($signed(b));
    else if (f == 6'h22) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic m_clear_ctl();
    m_valid = 0; m_wb = 0; m_br = 0; m_mr = 0; m_mw = 0; m_ovf = 0;
    m_full = 0; m_mulent = 0;
  endtask

  task automatic m_load_mult();
    m_clear_ctl();
    m_valid = 1; m_mulent = 1; m_alu = m_lo; m_zero = (m_lo == 0); m_dst = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] b;
    if (!rst_n) begin
      m_clear_ctl();
      m_alu = 0; m_bt = 0; m_rd2 = 0; m_dst = 0; m_zero = 0;
      m_hi = 0; m_lo = 0; m_left = 0; m_wait = 0;
    end else begin
      b = alusrc ? s_extend : rdata2;
      if (flush) begin
        m_clear_ctl();
        m_left = 0; m_wait = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_prod;
          if (!out_stall) m_load_mult(); else m_wait = 1;
        end
      end else if (m_wait) begin
        if (!out_stall) begin m_load_mult(); m_wait = 0; end
      end else if (!out_stall) begin
        if (in_valid && aluop == 2'b10 && funct == 6'h18) begin
          m_prod = longint'($signed(rdata1)) * longint'($signed(b));
          m_left = XLEN;
          m_clear_ctl();
        end else if (in_valid) begin
          m_clear_ctl();
          m_valid = 1; m_full = 1;
          m_ovf = ref_ovf(aluop, funct, rdata1, b);
          m_wb  = m_ovf ? 2'b00 : wb_ctl;
          {m_br, m_mr, m_mw} = m_ctl;
          m_alu = ref_alu(aluop, funct, rdata1, b);
          m_zero = (m_alu == 0);
          m_bt  = npc + s_extend * 4;
          m_rd2 = rdata2;
          m_dst = regdst ? rd_addr : rt_addr;
        end else begin
          m_clear_ctl();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("valid", exmem_valid, m_valid);
      chk("wb_ctl", exmem_wb_ctl, m_wb);
      chk("branch", exmem_branch, m_br);
      chk("memread", exmem_memread, m_mr);
      chk("memwrite", exmem_memwrite, m_mw);
      chk("ex_ovf", ex_ovf, m_ovf);
      chk("in_ready", in_ready, rst_n && m_left == 0 && !m_wait && !out_stall);
      if (m_full || m_mulent) begin
        chk("alu_result", exmem_alu_result, m_alu);
        chk("zero", exmem_zero, m_zero);
        chk("dst", exmem_dst, m_dst);
      end
      if (m_full) begin
        chk("btarget", exmem_btarget, m_bt);
        chk("rdata2", exmem_rdata2, m_rd2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    in_valid = 0; funct = 0; aluop = 0; wb_ctl = 0; m_ctl = 0;
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] bb,
                       input logic [4:0] rd, input logic [1:0] wb);
    in_valid = 1; aluop = 2'b10; funct = f; rdata1 = a; rdata2 = bb;
    regdst = 1; alusrc = 0; rd_addr = rd; rt_addr = 5'd3; wb_ctl = wb;
    m_ctl = 0; npc = 32'h40; s_extend = 32'h4;
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        src;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8] = '{
    '{2'b10, 6'h22, 32'd50,       32'd8,        1'b0, 32'd42},
    '{2'b10, 6'h24, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000},
    '{2'b10, 6'h25, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000FFF0},
    '{2'b10, 6'h27, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFF},
    '{2'b10, 6'h2a, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1},
    '{2'b10, 6'h2a, 32'd1,        32'hFFFFFFFF, 1'b0, 32'd0},
    '{2'b10, 6'h3f, 32'd9,        32'd9,        1'b0, 32'd0},
    '{2'b11, 6'h00, 32'd5,        32'd100,      1'b1, 32'd8}
  };

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    step(); step();
    chk("rst_valid", exmem_valid, 1'b0);
    chk("rst_alu", exmem_alu_result, 32'd0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_ovf", ex_ovf, 1'b0);
    rst_n = 1; cmp_en = 1;

    // add
    set_r(6'h20, 32'd10, 32'd20, 5'd10, 2'b10);
    step();
    chk("add_res", exmem_alu_result, 32'd30);
    chk("add_dst", exmem_dst, 5'd10);
    chk("add_wb", exmem_wb_ctl, 2'b10);
    chk("add_valid", exmem_valid, 1'b1);
    idle(); step();
    chk("bubble_valid", exmem_valid, 1'b0);

    // beq
    in_valid = 1; aluop = 2'b01; m_ctl = 3'b100; wb_ctl = 0; regdst = 0; alusrc = 0;
    rdata1 = 32'd15; rdata2 = 32'd15; npc = 32'd100; s_extend = 32'd8; rt_addr = 5'd7;
    step();
    chk("beq_zero", exmem_zero, 1'b1);
    chk("beq_branch", exmem_branch, 1'b1);
    chk("beq_target", exmem_btarget, 32'd132);

    // back-to-back ALU table
    for (int i = 0; i < 8; i++) begin
      set_r(vecs[i].f, vecs[i].a, vecs[i].b, 5'd2, 2'b10);
      aluop = vecs[i].op; alusrc = vecs[i].src; s_extend = 32'd3;
      step();
      chk("vec_res", exmem_alu_result, vecs[i].exp);
    end

    // MULT -3 * 7
    set_r(6'h18, 32'hFFFFFFFD, 32'd7, 5'd1, 2'b10);
    step(); idle();
    n = 0;
    while (!in_ready && n < 100) begin n++; step(); end
    chk("mult_busy_cycles", n, 32);
    chk("mult_valid", exmem_valid, 1'b1);
    chk("mult_wb", exmem_wb_ctl, 2'b00);
    chk("mult_lo_entry", exmem_alu_result, 32'hFFFFFFEB);
    set_r(6'h12, 0, 0, 5'd4, 2'b10); step();
    chk("mflo", exmem_alu_result, 32'hFFFFFFEB);
    set_r(6'h10, 0, 0, 5'd4, 2'b10); step();
    chk("mfhi", exmem_alu_result, 32'hFFFFFFFF);

    // stall holding an add result with new work pending
    set_r(6'h20, 32'd1, 32'd2, 5'd4, 2'b10); step();
    out_stall = 1;
    set_r(6'h20, 32'd100, 32'd200, 5'd5, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_res", exmem_alu_result, 32'd3);
      chk("stall_dst", exmem_dst, 5'd4);
      chk("stall_ready", in_ready, 1'b0);
    end
    out_stall = 0; step();
    chk("unstall_res", exmem_alu_result, 32'd300);

    // stall across MULT completion
    set_r(6'h18, 32'd5, 32'd6, 5'd1, 2'b10); step(); idle();
    repeat (31) step();
    out_stall = 1; step();
    chk("muldone_valid", exmem_valid, 1'b0);
    step(); step();
    chk("muldone_ready", in_ready, 1'b0);
    out_stall = 0; step();
    chk("release_valid", exmem_valid, 1'b1);
    chk("release_res", exmem_alu_result, 32'd30);

    // flush at MULT cycle 10
    set_r(6'h18, 32'd100, 32'd3, 5'd1, 2'b10); step(); idle();
    repeat (9) step();
    flush = 1; step(); flush = 0;
    chk("flush_valid", exmem_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    set_r(6'h12, 0, 0, 5'd4, 2'b10); step();
    chk("flush_lo_kept", exmem_alu_result, 32'd30);
    // flush drops a presented instruction
    set_r(6'h20, 32'd1, 32'd1, 5'd6, 2'b10); flush = 1; step(); flush = 0; idle();
    chk("flush_drop", exmem_valid, 1'b0);
    // flush on the completing edge discards the product
    set_r(6'h18, 32'd2, 32'd2, 5'd1, 2'b10); step(); idle();
    repeat (31) step();
    flush = 1; step(); flush = 0;
    chk("flush_done_valid", exmem_valid, 1'b0);
    set_r(6'h12, 0, 0, 5'd4, 2'b10); step();
    chk("flush_done_lo", exmem_alu_result, 32'd30);

    // async reset mid-MULT
    set_r(6'h18, 32'd7, 32'd7, 5'd1, 2'b10); step(); idle();
    repeat (5) step();
    rst_n = 0; #1;
    chk("arst_valid", exmem_valid, 1'b0);
    chk("arst_alu", exmem_alu_result, 32'd0);
    chk("arst_bt", exmem_btarget, 32'd0);
    chk("arst_ready", in_ready, 1'b0);
    step(); step();
    rst_n = 1;
    set_r(6'h12, 0, 0, 5'd4, 2'b10); step();
    chk("arst_lo", exmem_alu_result, 32'd0);
    chk("arst_lo_valid", exmem_valid, 1'b1);

    // overflow behaviour
    set_r(6'h20, 32'h7FFFFFFF, 32'd1, 5'd9, 2'b10); step();
    chk("ovf_add_flag", ex_ovf, TRAP);
    chk("ovf_add_wb", exmem_wb_ctl, TRAP ? 2'b00 : 2'b10);
    chk("ovf_add_res", exmem_alu_result, 32'h80000000);
    set_r(6'h21, 32'h7FFFFFFF, 32'd1, 5'd9, 2'b10); step();
    chk("addu_flag", ex_ovf, 1'b0);
    chk("addu_res", exmem_alu_result, 32'h80000000);
    set_r(6'h22, 32'h80000000, 32'd1, 5'd9, 2'b10); step();
    chk("ovf_sub_flag", ex_ovf, TRAP);
    set_r(6'h20, 32'h7FFFFFFF, 32'd1, 5'd9, 2'b10); aluop = 2'b00; step();
    chk("aluop00_flag", ex_ovf, 1'b0);
    idle(); step();
    chk("ovf_cleared", ex_ovf, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
- Parametrised, registered successor to the combinational MIPS execute stage.
- Contains the ALU, branch-target adder and destination-register mux, plus an owned EX/MEM pipeline register.
- Adds a valid/ready handshake, stall and flush handling, and an iterative signed MULT unit that writes HI/LO over XLEN cycles.
- Sits between the ID/EX register and the memory stage.

Parameters:
- XLEN, 32: datapath width; must be ≥8 and even.
- RA_W, 5: register-address width.
- CNT_W, $clog2(XLEN): multiplier step-counter width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ID/EX holds a valid instruction.
- in_ready  out  1  stage accepts this cycle. Transfer occurs when in_valid & in_ready.
- flush  in  1  synchronous kill of EX/MEM contents and of any in-flight MULT.
- out_stall  in  1  MEM stage cannot take a new entry.
- wb_ctl  in  2  {RegWrite, MemToReg}.
- m_ctl  in  3  {Branch, MemRead, MemWrite}.
- regdst, alusrc  in  1 each  select rd / select immediate.
- aluop  in  2  00 add, 01 sub, 10 funct-decode, 11 reserved (treated as add).
- npc, rdata1, rdata2, s_extend  in  XLEN each  next PC, operands, sign-extended immediate.
- rt_addr, rd_addr  in  RA_W each  instr[20:16], instr[15:11].
- funct  in  6  R-type function field.
- exmem_valid  out  1  EX/MEM entry valid.
- exmem_wb_ctl  out  2  registered wb_ctl.
- exmem_branch, exmem_memread, exmem_memwrite  out  1 each  registered m_ctl bits.
- exmem_btarget  out  XLEN  npc + (s_extend << 2), modulo 2^XLEN.
- exmem_zero  out  1  ALU result == 0.
- exmem_alu_result  out  XLEN  registered ALU result.
- exmem_rdata2  out  XLEN  store data.
- exmem_dst  out  RA_W  regdst ? rd_addr : rt_addr.
- ex_ovf  out  1  signed overflow flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All exmem_* outputs, ex_ovf, HI and LO clear to 0.
  - State is IDLE, count is 0.
  - in_ready is 0 while rst_n=0.
- ALU operand B = alusrc ? s_extend : rdata2.
- funct decode (aluop=10):
  - 100000 / 100001 add
  - 100010 / 100011 sub
  - 100100 and
  - 100101 or
  - 100111 nor
  - 101010 slt (signed; result 1 or 0)
  - 010000 mfhi (result = HI)
  - 010010 mflo (result = LO)
  - 011000 mult
  - any other funct: result 0
- in_ready = (state==IDLE) & ~out_stall.
- Non-MULT latency: 1 cycle. On a transfer edge, EX/MEM loads all fields and exmem_valid=1.
- Bubble: when in_valid=0, in_ready=1 and state==IDLE, EX/MEM loads exmem_valid=0 with wb_ctl and m_ctl fields forced to 0.
- out_stall=1: EX/MEM holds every field.
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
  - IDLE → MUL_BUSY on transfer of a MULT. Operands are latched and count=0. EX/MEM loads a bubble.
  - MUL_BUSY: one shift-add step per edge on operand magnitudes, then count++. On the edge where count==XLEN-1:
    - HI:LO is written with the sign-corrected 2·XLEN product.
    - If ~out_stall: EX/MEM loads the MULT entry (valid=1, wb_ctl=00, m_ctl=000, alu_result=LO, dst=0) and state → IDLE.
    - Otherwise state → MUL_DONE.
  - MUL_DONE → IDLE on the first edge with ~out_stall, loading the MULT entry.
  - in_ready=0 throughout MUL_BUSY and MUL_DONE, i.e. for XLEN cycles minimum after accept.
- mfhi/mflo accepted in IDLE read the committed HI/LO. No MULT is ever in flight when these are read.
- flush=1 at an edge:
  - exmem_valid ← 0; wb_ctl and m_ctl fields ← 0.
  - State → IDLE and count → 0; HI/LO unchanged (MULT aborted).
  - Any instruction presented that cycle is dropped.
- flush has priority over out_stall and over a MULT completing on the same edge. The MULT result is discarded; HI/LO stay unchanged.
- An asynchronous reset mid-MULT aborts it identically and clears HI/LO.

Optional Feature:
- Macro: EXE_OVF_TRAP_EN.
- Defined:
  - Signed overflow on funct 100000 (add) or 100010 (sub) under aluop=10 sets ex_ovf=1 in the EX/MEM entry and forces exmem_wb_ctl=00.
  - addu/subu (100001, 100011) and aluop=00/01 never set the flag.
  - ex_ovf clears on the next load.
- Undefined: ex_ovf is tied to 0; add/sub wrap silently.

Decomposition:
- Package exe_pkg:
  - funct code constants
  - aluop encodings
  - FSM state enum {IDLE, MUL_BUSY, MUL_DONE}
  - EX/MEM entry struct
- Sub-module seq_mult (parametrised by XLEN):
  - Iterative signed shift-add multiplier with start / done / abort.
  - Owns count and the partial product.
  - exe_stage_pipe owns HI/LO and the EX/MEM register.

Test Plan:
1. add: aluop=10, funct=100000, rdata1=10, rdata2=20, regdst=1, rd_addr=10, wb_ctl=10 → next edge: exmem_alu_result=30, exmem_dst=10, exmem_wb_ctl=10, exmem_valid=1.
2. beq: m_ctl=100, aluop=01, rdata1=rdata2=15, npc=100, s_extend=8 → exmem_zero=1, exmem_branch=1, exmem_btarget=132.
3. MULT: rdata1=-3, rdata2=7 → in_ready=0 for 32 cycles; then HI=FFFFFFFF, LO=FFFFFFEB and exmem_wb_ctl=00. A following mflo gives exmem_alu_result=FFFFFFEB.
4. out_stall=1 held 3 cycles after an add result, with new instructions pending → EX/MEM unchanged, in_ready=0. Also hold out_stall across MULT completion → state MUL_DONE, entry loads on the release edge.
5. flush asserted at MULT cycle 10 → exmem_valid=0, in_ready=1 next cycle, HI/LO retain prior values. Also: rst_n pulsed low mid-MULT → all outputs 0 immediately.
6. EXE_OVF_TRAP_EN defined: add 7FFFFFFF+1 → ex_ovf=1, exmem_wb_ctl=00. addu with the same operands → ex_ovf=0, result 80000000. Macro undefined: ex_ovf=0 in every case.
